// File: rtl/cache_refill_unit.sv
// Refill engine: turns a cache line miss into single-word bus reads.
// Define CACHE_REFILL_CWF_EN to fetch the critical (addressed) word first.
module cache_refill_unit #(
  parameter int unsigned NrWordsPerLine = 4,
  localparam int unsigned LineSize = 32 * NrWordsPerLine,
  localparam int unsigned BeatBits = $clog2(NrWordsPerLine)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_en_i,
  input  logic [31:0]         req_addr_i,
  output logic                line_valid_o,
  output logic [LineSize-1:0] line_data_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [31:0]         mem_req_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [31:0]         mem_rsp_data_i
);

  localparam int unsigned TagBits = 30 - BeatBits;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [TagBits-1:0]  line_addr_q, line_addr_d;
  logic [BeatBits-1:0] beat_q, beat_d;
  logic [BeatBits-1:0] cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                line_valid_q, line_valid_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [31:0]         mem_req_addr_q, mem_req_addr_d;
  logic [LineSize-1:0] line_data_q, line_data_d;

  logic [TagBits-1:0]  req_tag;
  logic [BeatBits-1:0] start_beat;
  logic [BeatBits-1:0] beat_nxt;

  assign req_tag  = req_addr_i[31:BeatBits+2];
  assign beat_nxt = beat_q + BeatBits'(1);

`ifdef CACHE_REFILL_CWF_EN
  logic [1:0] unused_addr;
  assign unused_addr = req_addr_i[1:0];
  assign start_beat  = req_addr_i[BeatBits+1:2];
`else
  logic [BeatBits+1:0] unused_addr;
  assign unused_addr = req_addr_i[BeatBits+1:0];
  assign start_beat  = '0;
`endif

  // Next-state and next-output logic; outputs are registered from *_d.
  // cnt counts responses independently of beat, so wrap order
  // never changes when the refill ends.
  always_comb begin
    state_d         = state_q;
    line_addr_d     = line_addr_q;
    beat_d          = beat_q;
    cnt_d           = cnt_q;
    abort_d         = abort_q;
    line_valid_d    = 1'b0;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    line_data_d     = line_data_q;
    unique case (state_q)
      IDLE: begin
        mem_req_valid_d = 1'b0;
        if (req_en_i) begin
          line_addr_d     = req_tag;
          beat_d          = start_beat;
          cnt_d           = '0;
          abort_d         = 1'b0;
          state_d         = REQ;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {req_tag, start_beat, 2'b00};
        end
      end
      REQ: begin
        if (!req_en_i) abort_d = 1'b1;
        if (mem_req_ready_i) begin
          state_d         = RESP;
          mem_req_valid_d = 1'b0;
        end
      end
      RESP: begin
        if (!req_en_i) abort_d = 1'b1;
        if (mem_rsp_valid_i) begin
          line_data_d[32*beat_q +: 32] = mem_rsp_data_i;
          cnt_d = cnt_q + BeatBits'(1);
          if (&cnt_q) begin
            state_d      = DONE;
            line_valid_d = ~(abort_q | ~req_en_i);
          end else begin
            beat_d          = beat_nxt;
            state_d         = REQ;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {line_addr_q, beat_nxt, 2'b00};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      line_addr_q     <= '0;
      beat_q          <= '0;
      cnt_q           <= '0;
      abort_q         <= 1'b0;
      line_valid_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      line_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      line_addr_q     <= line_addr_d;
      beat_q          <= beat_d;
      cnt_q           <= cnt_d;
      abort_q         <= abort_d;
      line_valid_q    <= line_valid_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      line_data_q     <= line_data_d;
    end
  end

  assign line_valid_o    = line_valid_q;
  assign line_data_o     = line_data_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit with a cycle-level reference model.
// Honours CACHE_REFILL_CWF_EN for the critical-word-first ordering.
module tb_cache_refill_unit;

  localparam int N = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          req_en_i = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic          line_valid_o;
  logic [127:0]  line_data_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [31:0]   mem_req_addr_o;
  logic          mem_rsp_valid_i = 1'b0;
  logic [31:0]   mem_rsp_data_i = '0;

  cache_refill_unit #(.NrWordsPerLine(N)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .req_en_i        (req_en_i),
    .req_addr_i      (req_addr_i),
    .line_valid_o    (line_valid_o),
    .line_data_o     (line_data_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: a refill is a list of N word reads on one line,
  // each a request handshake followed by one response.
  logic [31:0]  m_data [N];
  logic [31:0]  m_base = '0;
  bit           m_act = 0, m_wait = 0, m_done = 0, m_abort = 0;
  int           m_beat = 0, m_cnt = 0;
  logic         e_lv = 1'b0, e_rv = 1'b0;
  logic [31:0]  e_addr = '0;
  logic [127:0] e_data;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N; i++) m_data[i] = '0;
      m_act = 0; m_wait = 0; m_done = 0; m_abort = 0;
      m_beat = 0; m_cnt = 0;
      e_lv = 1'b0; e_rv = 1'b0; e_addr = '0;
    end else if (m_done) begin
      m_done = 0;
      e_lv = 1'b0;
    end else if (!m_act) begin
      if (req_en_i) begin
        m_act = 1; m_wait = 0; m_abort = 0; m_cnt = 0;
        m_base = req_addr_i & ~32'hF;
`ifdef CACHE_REFILL_CWF_EN
        m_beat = int'(req_addr_i[3:2]);
`else
        m_beat = 0;
`endif
        e_rv = 1'b1;
        e_addr = m_base + 32'(4 * m_beat);
      end
    end else begin
      if (!req_en_i) m_abort = 1;
      if (!m_wait) begin
        if (mem_req_ready_i) begin
          m_wait = 1;
          e_rv = 1'b0;
        end
      end else if (mem_rsp_valid_i) begin
        m_data[m_beat] = mem_rsp_data_i;
        m_cnt++;
        if (m_cnt == N) begin
          m_act = 0;
          m_done = 1;
          e_lv = !m_abort;
        end else begin
          m_beat = (m_beat + 1) % N;
          m_wait = 0;
          e_rv = 1'b1;
          e_addr = m_base + 32'(4 * m_beat);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    for (int i = 0; i < N; i++) e_data[32*i +: 32] = m_data[i];
    chk("cyc_line_valid", 128'(line_valid_o), 128'(e_lv));
    chk("cyc_req_valid", 128'(mem_req_valid_o), 128'(e_rv));
    if (e_rv) chk("cyc_req_addr", 128'(mem_req_addr_o), 128'(e_addr));
    chk("cyc_line_data", line_data_o, e_data);
  end

  logic [31:0] addr_log [$];

  // One refill; responses arrive the cycle after acceptance with
  // data base + word index. lat is the cycle of the DONE state.
  task automatic refill(input logic [31:0] a, input logic [31:0] base,
                        input int stall_beat, input int stall_n,
                        input int drop_beat, input bit hold,
                        output int lat, output int pulses, output int nrsp);
    int cyc, acc, st, done_cyc;
    bit pend;
    logic [31:0] pa;
    cyc = 0; acc = 0; st = 0; done_cyc = -1; pend = 0; pa = '0;
    lat = -1; pulses = 0; nrsp = 0;
    addr_log.delete();
    @(posedge clk_i); #1;
    req_en_i = 1'b1; req_addr_i = a;
    mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0;
    while (lat < 0 && cyc < 64) begin
      @(posedge clk_i); #1;
      cyc++;
      mem_rsp_valid_i = 1'b0;
      mem_req_ready_i = 1'b0;
      if (line_valid_o) pulses++;
      if (pend) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = base + 32'(pa[3:2]);
        pend = 0;
        nrsp++;
        if (nrsp == N) done_cyc = cyc + 1;
      end else if (mem_req_valid_o) begin
        if (acc == drop_beat) req_en_i = 1'b0;
        if (acc == stall_beat && st < stall_n) begin
          st++;
        end else begin
          mem_req_ready_i = 1'b1;
          addr_log.push_back(mem_req_addr_o);
          pa = mem_req_addr_o;
          acc++;
          pend = 1;
        end
      end
      if (cyc == done_cyc) begin
        lat = cyc;
        if (!hold) req_en_i = 1'b0;
      end
    end
    chk("refill_finished", 128'(lat >= 0), 128'(1));
  endtask

  int lat, pul, nr, lat2, pul2, nr2;

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_line_valid", 128'(line_valid_o), 128'(0));
    chk("rst_req_valid", 128'(mem_req_valid_o), 128'(0));
    chk("rst_req_addr", 128'(mem_req_addr_o), 128'(0));
    chk("rst_line_data", line_data_o, 128'(0));
    rstn_i = 1'b1;

    refill(32'h1230, 32'hA0, -1, 0, -1, 0, lat, pul, nr);
    chk("basic_lat", 128'(lat), 128'(9));
    chk("basic_pulses", 128'(pul), 128'(1));
    chk("basic_a0", 128'(addr_log[0]), 128'(32'h1230));
    chk("basic_a1", 128'(addr_log[1]), 128'(32'h1234));
    chk("basic_a2", 128'(addr_log[2]), 128'(32'h1238));
    chk("basic_a3", 128'(addr_log[3]), 128'(32'h123C));
    chk("basic_data", line_data_o,
        {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    refill(32'h1230, 32'hB0, 1, 3, -1, 0, lat, pul, nr);
    chk("stall_lat", 128'(lat), 128'(12));
    chk("stall_a1", 128'(addr_log[1]), 128'(32'h1234));
    chk("stall_data", line_data_o,
        {32'hB3, 32'hB2, 32'hB1, 32'hB0});

    refill(32'h1230, 32'hC0, -1, 0, 2, 0, lat, pul, nr);
    chk("abort_nrsp", 128'(nr), 128'(4));
    chk("abort_pulses", 128'(pul), 128'(0));
    refill(32'h4000, 32'hD0, -1, 0, -1, 0, lat, pul, nr);
    chk("after_abort_lat", 128'(lat), 128'(9));
    chk("after_abort_a0", 128'(addr_log[0]), 128'(32'h4000));
    chk("after_abort_pulses", 128'(pul), 128'(1));

    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hDEAD;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("stray_data", line_data_o,
        {32'hD3, 32'hD2, 32'hD1, 32'hD0});

    refill(32'h1238, 32'hE0, -1, 0, -1, 0, lat, pul, nr);
    chk("cwf_lat", 128'(lat), 128'(9));
`ifdef CACHE_REFILL_CWF_EN
    chk("cwf_a0", 128'(addr_log[0]), 128'(32'h1238));
    chk("cwf_a1", 128'(addr_log[1]), 128'(32'h123C));
    chk("cwf_a2", 128'(addr_log[2]), 128'(32'h1230));
    chk("cwf_a3", 128'(addr_log[3]), 128'(32'h1234));
`else
    chk("cwf_a0", 128'(addr_log[0]), 128'(32'h1230));
    chk("cwf_a1", 128'(addr_log[1]), 128'(32'h1234));
    chk("cwf_a2", 128'(addr_log[2]), 128'(32'h1238));
    chk("cwf_a3", 128'(addr_log[3]), 128'(32'h123C));
`endif
    chk("cwf_data", line_data_o,
        {32'hE3, 32'hE2, 32'hE1, 32'hE0});

    refill(32'h5000, 32'h10, -1, 0, -1, 1, lat, pul, nr);
    refill(32'h6000, 32'h20, -1, 0, -1, 0, lat2, pul2, nr2);
    chk("b2b_lat1", 128'(lat), 128'(9));
    chk("b2b_pulses1", 128'(pul), 128'(1));
    chk("b2b_lat2", 128'(lat2), 128'(9));
    chk("b2b_pulses2", 128'(pul2), 128'(1));
    chk("b2b_a0", 128'(addr_log[0]), 128'(32'h6000));

    @(posedge clk_i); #1;
    req_en_i = 1'b1; req_addr_i = 32'h7000; mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h71;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    chk("pre_rst_valid", 128'(mem_req_valid_o), 128'(1));
    chk("pre_rst_addr", 128'(mem_req_addr_o), 128'(32'h7004));
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    #2;
    chk("mid_rst_line_valid", 128'(line_valid_o), 128'(0));
    chk("mid_rst_req_valid", 128'(mem_req_valid_o), 128'(0));
    chk("mid_rst_req_addr", 128'(mem_req_addr_o), 128'(0));
    chk("mid_rst_line_data", line_data_o, 128'(0));
    #1;
    rstn_i = 1'b1;
    req_en_i = 1'b0;
    mem_req_ready_i = 1'b0;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hBAD;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("late_rsp_data", line_data_o, 128'(0));
    chk("late_rsp_valid", 128'(line_valid_o), 128'(0));

    repeat (3) @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
